// File: rtl/seq_divider_pkg.sv
// ============================================================================
//  Module   : seq_divider_pkg
//  Purpose  : Shared definitions for the sequential divider: datapath width,
//             divide-by-zero quotient value and the FSM state encoding.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_divider_pkg;

  localparam int         DIV_WIDTH         = 8;
  localparam logic [7:0] DIV_ZERO_QUOTIENT = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

endpackage

`default_nettype wire

// File: rtl/seq_divider_if.sv
// ============================================================================
//  Module   : seq_divider_if
//  Purpose  : Request/result bundle between the control unit (master) and the
//             divider (slave).
//  Ports    : start, dividend, divisor            (master -> slave)
//             quotient, remainder, busy, done,
//             div_by_zero                         (slave -> master)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seq_divider_if;
  import seq_divider_pkg::*;

  logic                 start;
  logic [DIV_WIDTH-1:0] dividend;
  logic [DIV_WIDTH-1:0] divisor;
  logic [DIV_WIDTH-1:0] quotient;
  logic [DIV_WIDTH-1:0] remainder;
  logic                 busy;
  logic                 done;
  logic                 div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );

endinterface

`default_nettype wire

// File: rtl/seq_divider_div_step.sv
// ============================================================================
//  Module   : div_step
//  Purpose  : One restoring-division iteration (purely combinational).
//             Shifts the next dividend bit into the partial remainder and
//             keeps the trial subtraction only when it does not borrow.
//  Ports    : r_i, q_i, d_i  - partial remainder, quotient shift reg, divisor
//             r_o, q_o       - updated partial remainder and quotient
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_step
  import seq_divider_pkg::*;
(
  input  wire logic [DIV_WIDTH-1:0] r_i,
  input  wire logic [DIV_WIDTH-1:0] q_i,
  input  wire logic [DIV_WIDTH-1:0] d_i,
  output logic      [DIV_WIDTH-1:0] r_o,
  output logic      [DIV_WIDTH-1:0] q_o
);

  logic [DIV_WIDTH:0] w_s;
  logic [DIV_WIDTH:0] w_t;

  always_comb begin
    w_s = {r_i, q_i[DIV_WIDTH-1]};
    w_t = w_s - {1'b0, d_i};
    // w_t[MSB] is the borrow: set when the shifted remainder is below D.
    // Because R < D on entry, S < 2D, so a non-borrowing result fits 8 bits.
    if (!w_t[DIV_WIDTH]) begin
      r_o = w_t[DIV_WIDTH-1:0];
      q_o = {q_i[DIV_WIDTH-2:0], 1'b1};
    end else begin
      r_o = w_s[DIV_WIDTH-1:0];
      q_o = {q_i[DIV_WIDTH-2:0], 1'b0};
    end
  end

endmodule

`default_nettype wire

// File: rtl/seq_divider.sv
// ============================================================================
//  Module   : seq_divider
//  Purpose  : 8-bit unsigned restoring divider, one bit per clock, with a
//             start/busy/done handshake. Divide-by-zero finishes in one cycle
//             with quotient 8'hFF and remainder = dividend.
//  Ports    : clk  - clock, rising edge
//             rst  - synchronous active-high reset
//             bus  - seq_divider_if.slave (request operands, results, status)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_divider
  import seq_divider_pkg::*;
(
  input  wire logic          clk,
  input  wire logic          rst,
  seq_divider_if.slave       bus
);

  div_state_e           state_q, state_d;
  logic [DIV_WIDTH-1:0] q_q, q_d;
  logic [DIV_WIDTH-1:0] r_q, r_d;
  logic [DIV_WIDTH-1:0] d_q, d_d;
  logic [2:0]           cnt_q, cnt_d;
  logic                 dbz_q, dbz_d;

  logic [DIV_WIDTH-1:0] step_r;
  logic [DIV_WIDTH-1:0] step_q;

  div_step u_div_step (
    .r_i (r_q),
    .q_i (q_q),
    .d_i (d_q),
    .r_o (step_r),
    .q_o (step_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // DONE accepts a new request so operations can run back to back.
        if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
        if (bus.start) begin
          if (bus.divisor == '0) begin
            q_d     = DIV_ZERO_QUOTIENT;
            r_d     = bus.dividend;
            dbz_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            d_d     = bus.divisor;
            q_d     = bus.dividend;
            r_d     = '0;
            cnt_d   = 3'd7;
            dbz_d   = 1'b0;
            state_d = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        // start is deliberately not looked at here: operands stay latched.
        q_d = step_q;
        r_d = step_r;
        if (cnt_q == 3'd0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.quotient    = q_q;
  assign bus.remainder   = r_q;
  assign bus.busy        = (state_q == ST_RUN);
  assign bus.done        = (state_q == ST_DONE);
  assign bus.div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// ============================================================================
//  Module   : tb_seq_divider
//  Purpose  : Self-checking bench for seq_divider: table of directed divides,
//             hand-written handshake corner cases and a reference-model sweep.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_divider;

  typedef struct {
    logic [7:0] dd;
    logic [7:0] dv;
    logic [7:0] eq;
    logic [7:0] er;
    logic       edbz;
  } vec_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  seq_divider_if bus ();

  seq_divider dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge: issues the request in this cycle, follows the
  // handshake, and checks busy per cycle, latency and the final results.
  // pulse_at > 0 raises start (with 9/2) in that cycle of the operation.
  task automatic run_op(input string name, input logic [7:0] dd, input logic [7:0] dv,
                        input logic [7:0] eq, input logic [7:0] er, input logic edbz,
                        input int pulse_at);
    int cyc;
    bus.start    = 1'b1;
    bus.dividend = dd;
    bus.divisor  = dv;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    while (bus.done !== 1'b1 && cyc <= 20) begin
      check({name, " busy"}, {31'd0, bus.busy}, {31'd0, ~edbz});
      if (cyc == pulse_at) begin
        bus.start    = 1'b1;
        bus.dividend = 8'd9;
        bus.divisor  = 8'd2;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    check({name, " latency"}, cyc, edbz ? 32'd1 : 32'd9);
    check({name, " busy@done"}, {31'd0, bus.busy}, 32'd0);
    check({name, " quotient"}, {24'd0, bus.quotient}, {24'd0, eq});
    check({name, " remainder"}, {24'd0, bus.remainder}, {24'd0, er});
    check({name, " div_by_zero"}, {31'd0, bus.div_by_zero}, {31'd0, edbz});
  endtask

  task automatic check_cleared(input string name);
    check({name, " quotient"}, {24'd0, bus.quotient}, 32'd0);
    check({name, " remainder"}, {24'd0, bus.remainder}, 32'd0);
    check({name, " busy"}, {31'd0, bus.busy}, 32'd0);
    check({name, " done"}, {31'd0, bus.done}, 32'd0);
    check({name, " div_by_zero"}, {31'd0, bus.div_by_zero}, 32'd0);
  endtask

  initial begin
    vec_t       vecs[8];
    logic [7:0] dd, dv, eq, er;
    logic       edbz;

    n_vec = 0;
    n_err = 0;

    vecs[0] = '{dd: 8'd200, dv: 8'd7,   eq: 8'd28,  er: 8'd4,  edbz: 1'b0};
    vecs[1] = '{dd: 8'd255, dv: 8'd1,   eq: 8'd255, er: 8'd0,  edbz: 1'b0};
    vecs[2] = '{dd: 8'd5,   dv: 8'd9,   eq: 8'd0,   er: 8'd5,  edbz: 1'b0};
    vecs[3] = '{dd: 8'd0,   dv: 8'd3,   eq: 8'd0,   er: 8'd0,  edbz: 1'b0};
    vecs[4] = '{dd: 8'd255, dv: 8'd255, eq: 8'd1,   er: 8'd0,  edbz: 1'b0};
    vecs[5] = '{dd: 8'd128, dv: 8'd16,  eq: 8'd8,   er: 8'd0,  edbz: 1'b0};
    vecs[6] = '{dd: 8'd77,  dv: 8'd0,   eq: 8'hFF,  er: 8'd77, edbz: 1'b1};
    vecs[7] = '{dd: 8'd10,  dv: 8'd3,   eq: 8'd3,   er: 8'd1,  edbz: 1'b0};

    bus.start    = 1'b0;
    bus.dividend = 8'd0;
    bus.divisor  = 8'd0;
    rst          = 1'b1;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;
    @(negedge clk);
    check_cleared("after reset");

    // Directed table; entries 6 and 7 run back to back so 10/3 must clear
    // the div_by_zero flag left by 77/0.
    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d %0d/%0d", i, vecs[i].dd, vecs[i].dv),
             vecs[i].dd, vecs[i].dv, vecs[i].eq, vecs[i].er, vecs[i].edbz, 0);
      if (i == 0) begin
        // done is a single-cycle pulse; results hold afterwards.
        @(negedge clk);
        check("done pulse", {31'd0, bus.done}, 32'd0);
        check("hold quotient", {24'd0, bus.quotient}, 32'd28);
        check("hold remainder", {24'd0, bus.remainder}, 32'd4);
      end else if (i != 6) begin
        @(negedge clk);
      end
    end

    // start pulsed mid-run is ignored; start in the done cycle is accepted.
    @(negedge clk);
    run_op("100/9 ignore", 8'd100, 8'd9, 8'd11, 8'd1, 1'b0, 4);
    run_op("9/2 chained", 8'd9, 8'd2, 8'd4, 8'd1, 1'b0, 0);
    @(negedge clk);

    // Reset in cycle 5 of a divide clears everything at the next edge.
    bus.start    = 1'b1;
    bus.dividend = 8'd200;
    bus.divisor  = 8'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("busy before rst", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_cleared("mid-op reset");
    rst = 1'b0;
    @(negedge clk);
    run_op("50/5 after rst", 8'd50, 8'd5, 8'd10, 8'd0, 1'b0, 0);
    @(negedge clk);

    // Reference-model sweep including divisor 0.
    for (int i = 0; i < 1000; i++) begin
      dd = 8'($urandom_range(0, 255));
      dv = (i % 16 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      if (dv == 8'd0) begin
        eq = 8'hFF;
        er = dd;
        edbz = 1'b1;
      end else begin
        eq = dd / dv;
        er = dd % dv;
        edbz = 1'b0;
      end
      run_op($sformatf("rand%0d %0d/%0d", i, dd, dv), dd, dv, eq, er, edbz, 0);
      if (i % 2 == 1) begin
        @(negedge clk);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
